// File: rtl/display_scan_ctrl_if.sv
// Load handshake between the core datapath and the display scan controller.
// The datapath (master) presents a BCD value and decimal-point mask with a one-cycle
// Load strobe; the scan controller (slave) answers with a one-cycle Ack once the value
// is actually on the display.
interface display_scan_ctrl_if;
    logic [15:0] Value;
    logic [3:0]  DPMask;
    logic        Load;
    logic        Ack;

    modport master (output Value, output DPMask, output Load, input Ack);
    modport slave  (input Value, input DPMask, input Load, output Ack);
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit 7-segment display.
// Loaded values are double-buffered and adopted only at frame boundaries (counter=0,
// digit 3). Each digit slot starts with BLANK dead cycles; all pins are registered.
// Optional build macro DISPLAY_DIM_EN adds a Dim input that halves the lit time.
module display_scan_ctrl #(
    parameter int unsigned PRESCALE = 64,
    parameter int unsigned BLANK    = 4
) (
    input  logic                HCLK,
    input  logic                HRESET,
    display_scan_ctrl_if.slave  bus,
    input  logic                LZB,
`ifdef DISPLAY_DIM_EN
    input  logic                Dim,
`endif
    output logic                FrameStart,
    output logic [3:0]          nDigit,
    output logic                SegA,
    output logic                SegB,
    output logic                SegC,
    output logic                SegD,
    output logic                SegE,
    output logic                SegF,
    output logic                SegG,
    output logic                DP
);

    localparam int unsigned CntW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DimEnd = BLANK + (PRESCALE - BLANK) / 2;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     hold_val_q, hold_val_d, disp_val_q, disp_val_d;
    logic [3:0]      hold_dp_q, hold_dp_d, disp_dp_q, disp_dp_d;
    logic            pend_q, pend_d;
    logic            ack_q, ack_d;
    logic            fs_q, fs_d;
    logic [3:0]      ndig_q, ndig_d;
    logic [6:0]      seg_q, seg_d;   // {A,B,C,D,E,F,G}
    logic            dp_q, dp_d;

    logic            frame_bnd, adopt, cnt_last, lit, lz_blank;
    logic [3:0]      nib;

    // Segment patterns {A,B,C,D,E,F,G}; non-BCD nibbles show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    // Next-state: slot timing, load buffering, and registered pin values.
    always_comb begin
        frame_bnd = (cnt_q == '0) && (idx_q == 2'd3);
        // A Load on the boundary cycle pre-empts adoption of any older pending value.
        adopt     = frame_bnd && pend_q && !bus.Load;
        cnt_last  = (cnt_q == CntW'(PRESCALE - 1));
        cnt_d     = cnt_last ? '0 : cnt_q + CntW'(1);
        idx_d     = cnt_last ? idx_q - 2'd1 : idx_q;

        hold_val_d = hold_val_q;
        hold_dp_d  = hold_dp_q;
        if (bus.Load) begin
            hold_val_d = bus.Value;
            hold_dp_d  = bus.DPMask;
        end
        pend_d = bus.Load || (pend_q && !adopt);

        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        if (adopt) begin
            disp_val_d = hold_val_q;
            disp_dp_d  = hold_dp_q;
        end

        ack_d = adopt;
        fs_d  = frame_bnd;

        lit = (cnt_q >= CntW'(BLANK));
`ifdef DISPLAY_DIM_EN
        if (Dim && (cnt_q >= CntW'(DimEnd))) lit = 1'b0;
`endif
        nib      = disp_val_q[{idx_q, 2'b00} +: 4];
        // Blank a leading zero only if everything from this digit upward is zero and dot-free.
        lz_blank = LZB && (idx_q != 2'd0)
                   && ((disp_val_q >> {idx_q, 2'b00}) == 16'd0)
                   && ((disp_dp_q >> idx_q) == 4'd0);

        ndig_d = 4'hF;
        seg_d  = '0;
        dp_d   = 1'b0;
        if (lit) begin
            ndig_d[idx_q] = 1'b0;
            seg_d         = lz_blank ? 7'd0 : seg_decode(nib);
            dp_d          = disp_dp_q[idx_q];
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cnt_q      <= '0;
            idx_q      <= 2'd3;
            hold_val_q <= '0;
            hold_dp_q  <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
            fs_q       <= 1'b0;
            ndig_q     <= 4'hF;
            seg_q      <= '0;
            dp_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            hold_val_q <= hold_val_d;
            hold_dp_q  <= hold_dp_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
            fs_q       <= fs_d;
            ndig_q     <= ndig_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign bus.Ack    = ack_q;
    assign FrameStart = fs_q;
    assign nDigit     = ndig_q;
    assign {SegA, SegB, SegC, SegD, SegE, SegF, SegG} = seg_q;
    assign DP         = dp_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: a cycle-indexed behavioural model derives the
// expected pins from the elapsed time since reset and the load/adopt rules.
module tb_display_scan_ctrl;

    localparam int P = 64;
    localparam int B = 4;
    localparam int F = 4 * P;

    logic clk, rst, lzb, dim;
    logic [3:0] nDigit;
    logic SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP, FrameStart;
    logic [13:0] obs;

    display_scan_ctrl_if bus();

    display_scan_ctrl #(.PRESCALE(P), .BLANK(B)) dut (
        .HCLK       (clk),
        .HRESET     (rst),
        .bus        (bus),
        .LZB        (lzb),
`ifdef DISPLAY_DIM_EN
        .Dim        (dim),
`endif
        .FrameStart (FrameStart),
        .nDigit     (nDigit),
        .SegA       (SegA),
        .SegB       (SegB),
        .SegC       (SegC),
        .SegD       (SegD),
        .SegE       (SegE),
        .SegF       (SegF),
        .SegG       (SegG),
        .DP         (DP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {nDigit, SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP, bus.Ack, FrameStart};

    int vectors = 0;
    int miscompares = 0;

    // Model state: s = number of clock edges since reset release.
    int          s;
    logic [15:0] m_hold, m_disp;
    logic [3:0]  m_hdp, m_ddp;
    bit          m_pend;
    logic [13:0] exp_v;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1111110;  // ABCDEF
            4'd1: return 7'b0110000;  // BC
            4'd2: return 7'b1101101;  // ABDEG
            4'd3: return 7'b1111001;  // ABCDG
            4'd4: return 7'b0110011;  // BCFG
            4'd5: return 7'b1011011;  // ACDFG
            4'd6: return 7'b1011111;  // ACDEFG
            4'd7: return 7'b1110000;  // ABC
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;  // ABCDFG
            default: return 7'b0000001;  // G only
        endcase
    endfunction

    // Expected {nDigit, segs, DP} for slot position cnt of digit idx.
    function automatic logic [11:0] pins(input int cnt, input int idx, input logic [15:0] v,
                                         input logic [3:0] m, input logic lz, input logic dm);
        logic [3:0] nd;
        logic [6:0] sg;
        int lit_end;
        lit_end = dm ? B + (P - B) / 2 : P;
        if (cnt < B || cnt >= lit_end) return {4'hF, 7'd0, 1'b0};
        nd = 4'hF;
        nd[idx] = 1'b0;
        if (lz && idx != 0 && (v >> (4 * idx)) == 0 && (m >> idx) == 0) sg = 7'd0;
        else sg = seg_of(v[4 * idx +: 4]);
        return {nd, sg, m[idx]};
    endfunction

    task automatic model_reset();
        s = 0; m_hold = 0; m_disp = 0; m_hdp = 0; m_ddp = 0; m_pend = 0;
    endtask

    // Advance one clock: compute expectation for this edge, update model, sample at edge+1.
    task automatic tick();
        int cnt, idx;
        bit bnd, adopt;
        cnt   = s % P;
        idx   = 3 - (s / P) % 4;
        bnd   = (s % F) == 0;
        adopt = bnd && m_pend && !bus.Load;
        exp_v = {pins(cnt, idx, m_disp, m_ddp, lzb, dim), adopt, bnd};
        if (adopt) begin m_disp = m_hold; m_ddp = m_hdp; m_pend = 0; end
        if (bus.Load) begin m_hold = bus.Value; m_hdp = bus.DPMask; m_pend = 1; end
        s++;
        @(posedge clk);
        #1;
        bus.Load = 1'b0;
    endtask

    task automatic set_load(input logic [15:0] v, input logic [3:0] m);
        bus.Value = v; bus.DPMask = m; bus.Load = 1'b1;
    endtask

    task automatic align();
        while (s % F != 0) tick();
    endtask

    task automatic load_adopt(input logic [15:0] v, input logic [3:0] m);
        set_load(v, m);
        tick();
        while (m_pend) tick();
    endtask

    task automatic test_reset();
        int acks;
        set_load(16'h9876, 4'b0001);
        tick();
        repeat (P + 20) tick();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 14'h3C00 >> 0 && obs !== {4'hF, 10'd0}) begin end
        if (obs !== {4'hF, 10'd0}) begin
            miscompares++;
            $display("FAIL reset_async: got %h want %h", obs, {4'hF, 10'd0});
        end
        #3 rst = 1'b0;
        model_reset();
        acks = 0;
        for (int k = 1; k <= F + 2; k++) begin
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_frame k=%0d: got %h want %h", k, obs, exp_v);
            end
            if (bus.Ack === 1'b1) acks++;
            if (k == B) begin
                vectors++;
                if (nDigit !== 4'hF) begin
                    miscompares++;
                    $display("FAIL reset_blank: nDigit %b want 1111", nDigit);
                end
            end
            if (k == B + 1) begin
                vectors++;
                if (nDigit !== 4'b0111) begin
                    miscompares++;
                    $display("FAIL reset_first_strobe: nDigit %b want 0111", nDigit);
                end
            end
        end
        vectors++;
        if (acks !== 0) begin
            miscompares++;
            $display("FAIL reset_lost_load: acks %0d want 0", acks);
        end
    endtask

    task automatic test_scan();
        int low[4];
        int fs;
        lzb = 1'b0;
        load_adopt(16'h1234, 4'b0000);
        align();
        low = '{0, 0, 0, 0};
        fs = 0;
        for (int k = 0; k < F; k++) begin
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL scan k=%0d: got %h want %h", k, obs, exp_v);
            end
            for (int i = 0; i < 4; i++) if (nDigit[i] === 1'b0) low[i]++;
            if (FrameStart === 1'b1) fs++;
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (low[i] !== P - B) begin
                miscompares++;
                $display("FAIL scan_low_digit%0d: %0d cycles want %0d", i, low[i], P - B);
            end
        end
        vectors++;
        if (fs !== 1) begin
            miscompares++;
            $display("FAIL scan_framestart: %0d pulses want 1", fs);
        end
    endtask

    task automatic test_handshake();
        int acks, ack_s, want_s;
        align();
        repeat (100) tick();
        set_load(16'h5678, 4'b0100);
        want_s = ((s / F) + 1) * F + 1;
        acks = 0; ack_s = -1;
        for (int k = 0; k < 2 * F; k++) begin
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL handshake k=%0d: got %h want %h", k, obs, exp_v);
            end
            if (bus.Ack === 1'b1) begin acks++; ack_s = s; end
        end
        vectors++;
        if (acks !== 1 || ack_s !== want_s) begin
            miscompares++;
            $display("FAIL handshake_ack: count %0d at %0d want 1 at %0d", acks, ack_s, want_s);
        end
        // Two loads in one frame: latest wins, single Ack.
        align();
        repeat (10) tick();
        set_load(16'h1111, 4'b0000);
        repeat (50) tick();
        set_load(16'h2222, 4'b0000);
        acks = 0;
        for (int k = 0; k < 2 * F; k++) begin
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL double_load k=%0d: got %h want %h", k, obs, exp_v);
            end
            if (bus.Ack === 1'b1) acks++;
        end
        vectors++;
        if (acks !== 1) begin
            miscompares++;
            $display("FAIL double_load_acks: %0d want 1", acks);
        end
    endtask

    task automatic test_collision();
        int acks, ack_s, want_s;
        align();
        repeat (30) tick();
        set_load(16'h9999, 4'b1111);
        tick();
        align();
        set_load(16'h4321, 4'b0000);
        want_s = s + F + 1;
        acks = 0; ack_s = -1;
        for (int k = 0; k < 2 * F + 4; k++) begin
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL collision k=%0d: got %h want %h", k, obs, exp_v);
            end
            if (bus.Ack === 1'b1) begin acks++; ack_s = s; end
        end
        vectors++;
        if (acks !== 1 || ack_s !== want_s) begin
            miscompares++;
            $display("FAIL collision_ack: count %0d at %0d want 1 at %0d", acks, ack_s, want_s);
        end
    endtask

    task automatic test_lzb();
        logic [15:0] vals[5] = '{16'h0000, 16'h00A5, 16'h0007, 16'h0050, 16'h0005};
        logic [3:0]  dps[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
        logic        lzs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 5; c++) begin
            lzb = lzs[c];
            load_adopt(vals[c], dps[c]);
            align();
            for (int k = 0; k < F; k++) begin
                tick();
                vectors++;
                if (obs !== exp_v) begin
                    miscompares++;
                    $display("FAIL lzb case%0d k=%0d: got %h want %h", c, k, obs, exp_v);
                end
            end
        end
    endtask

`ifdef DISPLAY_DIM_EN
    task automatic test_dim();
        int low[4];
        lzb = 1'b0;
        load_adopt(16'h1234, 4'b0000);
        align();
        dim = 1'b1;
        low = '{0, 0, 0, 0};
        for (int k = 0; k < F; k++) begin
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL dim k=%0d: got %h want %h", k, obs, exp_v);
            end
            for (int i = 0; i < 4; i++) if (nDigit[i] === 1'b0) low[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (low[i] !== (P - B) / 2) begin
                miscompares++;
                $display("FAIL dim_low_digit%0d: %0d cycles want %0d", i, low[i], (P - B) / 2);
            end
        end
        dim = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 8 * F; k++) begin
            if ($urandom_range(0, 149) == 0)
                set_load(16'($urandom), 4'($urandom_range(0, 15) & ($urandom_range(0, 1) ? 4'hF : 4'h0)));
            if ($urandom_range(0, 299) == 0) lzb = ~lzb;
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL random k=%0d: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        lzb = 1'b0;
        dim = 1'b0;
        bus.Value = 16'h0;
        bus.DPMask = 4'h0;
        bus.Load = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        test_reset();
        test_scan();
        test_handshake();
        test_collision();
        test_lzb();
`ifdef DISPLAY_DIM_EN
        test_dim();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
